// File: rtl/param_pkg.sv
// Shared parameters and controller state encoding for the
// multi-port data-bus memory.
package param_pkg;
   localparam int N_CPU     = 4;
   localparam int DBUS_AW   = 32;
   localparam int DBUS_DW   = 32;
   localparam int DBUS_ISEL = DBUS_DW / 8;
   localparam int MEM_WORDS = 1024;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the port after ptr
// and wraps; grant is one-hot (all zero if no request).
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/top.sv
// Shared byte-enabled word memory serving N_CPU data-bus ports
// one transaction at a time through a round-robin arbiter.
module top #(
   parameter int N_CPU     = param_pkg::N_CPU,
   parameter int DBUS_AW   = param_pkg::DBUS_AW,
   parameter int DBUS_DW   = param_pkg::DBUS_DW,
   parameter int DBUS_ISEL = param_pkg::DBUS_ISEL,
   parameter int MEM_WORDS = param_pkg::MEM_WORDS
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [N_CPU-1:0]             req_m2dbiu,
   input  logic [N_CPU*DBUS_AW-1:0]     adr_m2dbiu_flat,
   input  logic [N_CPU*DBUS_DW-1:0]     dat_m2dbiu_flat,
   input  logic [N_CPU-1:0]             we_m2dbiu,
   input  logic [N_CPU*DBUS_ISEL-1:0]   sel_m2dbiu_flat,
   output logic [N_CPU*DBUS_DW-1:0]     dat_dbiu2m_flat,
   output logic [N_CPU-1:0]             ack_dbiu2m
);
   import param_pkg::ST_IDLE;
   import param_pkg::ST_ACCESS;
   import param_pkg::ST_RESP;

   localparam int PW  = (N_CPU > 1) ? $clog2(N_CPU) : 1;
   localparam int OFF = $clog2(DBUS_ISEL);
   localparam int IW  = $clog2(MEM_WORDS);

   logic [1:0]           state;
   logic [PW-1:0]        ptr;
   logic [PW-1:0]        gidx;
   logic [PW-1:0]        gsel;
   logic [N_CPU-1:0]     grant;
   logic [IW-1:0]        idx_q;
   logic [DBUS_DW-1:0]   wdat_q;
   logic [DBUS_DW-1:0]   rdat_q;
   logic                 we_q;
   logic [DBUS_ISEL-1:0] sel_q;

   // Power-up contents are zero; reset deliberately leaves them alone.
   logic [DBUS_ISEL-1:0][7:0] mem [MEM_WORDS] = '{default: '0};

   rr_arbiter #(
      .N  (N_CPU),
      .PW (PW)
   ) u_arb (
      .req   (req_m2dbiu),
      .ptr   (ptr),
      .grant (grant)
   );

   always_comb begin
      gsel = '0;
      for (int i = 0; i < N_CPU; i++) begin
         if (grant[i]) gsel = PW'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         state  <= ST_IDLE;
         ptr    <= PW'(N_CPU - 1);
         gidx   <= '0;
         rdat_q <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (|req_m2dbiu) begin
                  gidx   <= gsel;
                  ptr    <= gsel;
                  idx_q  <= adr_m2dbiu_flat[gsel*DBUS_AW + OFF +: IW];
                  wdat_q <= dat_m2dbiu_flat[gsel*DBUS_DW +: DBUS_DW];
                  we_q   <= we_m2dbiu[gsel];
                  sel_q  <= sel_m2dbiu_flat[gsel*DBUS_ISEL +: DBUS_ISEL];
                  state  <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               rdat_q <= we_q ? '0 : mem[idx_q];
               state  <= ST_RESP;
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A reset landing on the ACCESS edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!resetn && state == ST_ACCESS && we_q) begin
         for (int b = 0; b < DBUS_ISEL; b++) begin
            if (sel_q[b]) mem[idx_q][b] <= wdat_q[b*8 +: 8];
         end
      end
   end

   always_comb begin
      ack_dbiu2m      = '0;
      dat_dbiu2m_flat = '0;
      if (state == ST_RESP) begin
         ack_dbiu2m[gidx] = 1'b1;
         dat_dbiu2m_flat[gidx*DBUS_DW +: DBUS_DW] = rdat_q;
      end
   end

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the shared data-bus memory: drivers push
// expected acks, a negedge monitor pops and compares them.
module tb_top;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic [N-1:0]  req;
   logic [N-1:0]  we;
   logic [N-1:0]  ack;
   logic [AW-1:0] adr [N];
   logic [DW-1:0] wd  [N];
   logic [SW-1:0] sel [N];
   logic [N*AW-1:0] adr_f;
   logic [N*DW-1:0] wd_f;
   logic [N*SW-1:0] sel_f;
   logic [N*DW-1:0] rd_f;

   for (genvar g = 0; g < N; g++) begin : g_flat
      assign adr_f[g*AW +: AW] = adr[g];
      assign wd_f[g*DW +: DW]  = wd[g];
      assign sel_f[g*SW +: SW] = sel[g];
   end

   top dut (
      .clk             (clk),
      .resetn          (resetn),
      .req_m2dbiu      (req),
      .adr_m2dbiu_flat (adr_f),
      .dat_m2dbiu_flat (wd_f),
      .we_m2dbiu       (we),
      .sel_m2dbiu_flat (sel_f),
      .dat_dbiu2m_flat (rd_f),
      .ack_dbiu2m      (ack)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          port;
      logic [31:0] data;
   } exp_t;

   exp_t sbq[$];
   int   ack_cyc[$];
   int   nvec = 0;
   int   nmis = 0;
   int   nack = 0;
   bit   mon_on = 1'b0;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic expect_ack(input int p, input logic [31:0] d);
      exp_t e;
      e.port = p;
      e.data = d;
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [127:0] want;
      if (mon_on) begin
         if (ack !== '0) begin
            nack++;
            ack_cyc.push_back(cyc);
            check("ack_onehot", 128'($onehot(ack)), 128'(1));
            if (sbq.size() == 0) begin
               check("unexpected_ack", 128'(ack), 128'(0));
            end else begin
               e    = sbq.pop_front();
               want = 128'(e.data) << (e.port * DW);
               check("ack_port", 128'(ack), 128'(1) << e.port);
               check("rdata", rd_f, want);
            end
         end else begin
            check("dat_idle", rd_f, 128'(0));
         end
      end
   end

   // Caller is at posedge+#1; returns cycles from request to ack.
   task automatic txn(input int p, input logic [31:0] a,
                      input logic [31:0] d, input logic w,
                      input logic [3:0] s, output int lat);
      int t0;
      bit got;
      got = 1'b0;
      adr[p] = a;
      wd[p]  = d;
      we[p]  = w;
      sel[p] = s;
      req[p] = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ack[p]) begin
            got = 1'b1;
            break;
         end
      end
      lat = cyc - t0;
      if (!got) begin
         nvec++;
         nmis++;
         $display("FAIL timeout port %0d: no ack, want ack", p);
      end
      @(posedge clk);
      #1;
      req[p] = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b1;
      req    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", 128'(ack), 128'(0));
      check("rst_dat", rd_f, 128'(0));
      resetn = 1'b0;
   endtask

   int l0, l1, l2, l3, na;

   initial begin
      resetn = 1'b0;
      req    = '0;
      we     = '0;
      for (int i = 0; i < N; i++) begin
         adr[i] = '0;
         wd[i]  = '0;
         sel[i] = '0;
      end
      @(posedge clk);
      #1;
      do_reset();
      mon_on = 1'b1;

      // basic write / read and latency
      expect_ack(0, 32'h0);
      txn(0, 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, l0);
      check("wr_latency", 128'(l0), 128'(2));
      expect_ack(0, 32'hDEADBEEF);
      txn(0, 32'h10, 32'h0, 1'b0, 4'hF, l0);
      check("rd_latency", 128'(l0), 128'(2));

      // byte-lane merge seen from another port
      expect_ack(1, 32'h0);
      txn(1, 32'h10, 32'h000000AA, 1'b1, 4'h1, l1);
      expect_ack(2, 32'hDEADBEAA);
      txn(2, 32'h10, 32'h0, 1'b0, 4'hF, l2);
      expect_ack(2, 32'hDEADBEAA);
      txn(2, 32'h10, 32'h0, 1'b0, 4'h0, l2);

      // simultaneous requests after reset: order 0,1,2,3
      do_reset();
      ack_cyc.delete();
      expect_ack(0, 32'h0);
      expect_ack(1, 32'h0);
      expect_ack(2, 32'hDEADBEAA);
      expect_ack(3, 32'h11111111);
      fork
         txn(0, 32'h100, 32'h11111111, 1'b1, 4'hF, l0);
         txn(1, 32'h104, 32'h22222222, 1'b1, 4'hF, l1);
         txn(2, 32'h10,  32'h0,        1'b0, 4'hF, l2);
         txn(3, 32'h100, 32'h0,        1'b0, 4'hF, l3);
      join
      check("simul_lat0", 128'(l0), 128'(2));
      check("simul_n", 128'(ack_cyc.size()), 128'(4));
      if (ack_cyc.size() == 4) begin
         for (int i = 1; i < 4; i++) begin
            check("simul_space", 128'(ack_cyc[i] - ack_cyc[i-1]),
                  128'(3));
         end
      end

      // fairness with CPU3 back-to-back: 0,1,3,0,1,3,3
      expect_ack(0, 32'h11111111);
      expect_ack(1, 32'h22222222);
      expect_ack(3, 32'h0);
      expect_ack(0, 32'h11111111);
      expect_ack(1, 32'h22222222);
      expect_ack(3, 32'h33333333);
      expect_ack(3, 32'h22222222);
      fork
         begin
            txn(0, 32'h100, 32'h0, 1'b0, 4'hF, l0);
            check("fair_wait0", 128'(l0 <= 14), 128'(1));
            txn(0, 32'h100, 32'h0, 1'b0, 4'hF, l0);
            check("fair_wait0", 128'(l0 <= 14), 128'(1));
         end
         begin
            txn(1, 32'h104, 32'h0, 1'b0, 4'hF, l1);
            check("fair_wait1", 128'(l1 <= 14), 128'(1));
            txn(1, 32'h104, 32'h0, 1'b0, 4'hF, l1);
            check("fair_wait1", 128'(l1 <= 14), 128'(1));
         end
         begin
            txn(3, 32'h200, 32'h33333333, 1'b1, 4'hF, l3);
            check("fair_wait3", 128'(l3 <= 14), 128'(1));
            txn(3, 32'h200, 32'h0, 1'b0, 4'hF, l3);
            check("fair_wait3", 128'(l3 <= 14), 128'(1));
            txn(3, 32'h104, 32'h0, 1'b0, 4'hF, l3);
            check("fair_wait3", 128'(l3 <= 14), 128'(1));
         end
      join

      // reset on the ACCESS edge of a write aborts it
      expect_ack(0, 32'h0);
      txn(0, 32'h20, 32'h5A5A5A5A, 1'b1, 4'hF, l0);
      na     = nack;
      adr[1] = 32'h20;
      wd[1]  = 32'hFFFFFFFF;
      we[1]  = 1'b1;
      sel[1] = 4'hF;
      req[1] = 1'b1;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      check("abort_ack", 128'(ack), 128'(0));
      resetn = 1'b0;
      req[1] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("abort_noack", 128'(nack), 128'(na));
      expect_ack(2, 32'h5A5A5A5A);
      txn(2, 32'h20, 32'h0, 1'b0, 4'hF, l2);

      // address wrap-around and partial write
      expect_ack(2, 32'h0);
      txn(2, 32'h0, 32'hCAFEF00D, 1'b1, 4'hF, l2);
      expect_ack(3, 32'hCAFEF00D);
      txn(3, 32'h1000, 32'h0, 1'b0, 4'hF, l3);
      expect_ack(3, 32'hCAFEF00D);
      txn(3, 32'h1003, 32'h0, 1'b0, 4'hF, l3);
      expect_ack(0, 32'h0);
      txn(0, 32'h0, 32'h12345678, 1'b1, 4'h6, l0);
      expect_ack(1, 32'hCA34560D);
      txn(1, 32'h0, 32'h0, 1'b0, 4'hF, l1);

      repeat (4) @(posedge clk);
      #1;
      check("sb_empty", 128'(sbq.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
